// File: rtl/keccak_fifo_pkg.sv
// Shared constants and types for the FIFO-to-Keccak rate-block drain.
// One rate block for SHA3-256 is 1088 bits, carried as 34 words of 32 bits.
package keccak_fifo_pkg;

    localparam int DW    = 32;  // FIFO word width
    localparam int NWORD = 34;  // words per rate block (34*32 = 1088)
    localparam int RDLAT = 1;   // FIFO read latency, get -> vld (legal 1..3)
    localparam int CW    = 6;   // word counter width, 2^CW > NWORD

    // FILL: collecting words from the FIFO; HOLD: block offered to the core.
    typedef enum logic [0:0] {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    typedef logic [NWORD*DW-1:0] blk_t;

endpackage

// File: rtl/fifo_get_ctrl.sv
// Read-request side of the drain: issues fifoget, tracks how many reads are
// still in flight, remembers a pending flush and flags stray read data.
//
// Handshake: fifoget is a one-cycle request, one word per high cycle; each
// request is answered by exactly one fifovld cycle some fixed latency later.
// A fifovld with no request in flight (or while a block is held) is a
// protocol error: the word is dropped and protoerr sticks until reset.
module fifo_get_ctrl
    import keccak_fifo_pkg::*;
(
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          hold_i,       // top FSM is in HOLD
    input  logic [CW-1:0] fill_i,       // words already stored
    input  logic          fifordy_i,
    input  logic          fifovld_i,
    input  logic          flush_i,
    output logic          fifoget_o,
    output logic          word_acc_o,   // fifodout is a wanted word this cycle
    output logic          close_o,      // a flush is in effect this cycle
    output logic          outs_zero_o,  // no read in flight after this edge
    output logic          protoerr_o
);

    logic [CW-1:0] outs_q, outs_d;
    logic          flushpend_q, flushpend_d;
    logic          protoerr_q, protoerr_d;
    logic [CW:0]   inflight;

    // Request gating, in-flight counting and flush/error next-state.
    always_comb begin
        // fill + outs at CW+1 bits so it can never wrap
        inflight    = {1'b0, fill_i} + {1'b0, outs_q};
        fifoget_o   = !hold_i && fifordy_i && !flushpend_q
                      && (inflight < (CW+1)'(NWORD));
        word_acc_o  = fifovld_i && !hold_i && (outs_q != '0);

        outs_d = outs_q;
        if (fifoget_o && !word_acc_o) begin
            outs_d = outs_q + CW'(1);
        end else if (!fifoget_o && word_acc_o) begin
            outs_d = outs_q - CW'(1);
        end

        // A flush seen in HOLD is ignored; in FILL it closes the block.
        close_o     = !hold_i && (flushpend_q || flush_i);
        outs_zero_o = (outs_d == '0);
        // Once nothing is in flight the top either enters HOLD or drops
        // the flush (empty block), so the pending flag is done either way.
        flushpend_d = close_o && !outs_zero_o;
        protoerr_d  = protoerr_q || (fifovld_i && !word_acc_o);
    end

    // Register in-flight count, pending flush and sticky error.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            outs_q      <= '0;
            flushpend_q <= 1'b0;
            protoerr_q  <= 1'b0;
        end else begin
            outs_q      <= outs_d;
            flushpend_q <= flushpend_d;
            protoerr_q  <= protoerr_d;
        end
    end

    assign protoerr_o = protoerr_q;

endmodule

// File: rtl/fifo_blk_drain.sv
// Read-clock-domain consumer of the dual-clock FIFO. Packs 32-bit words into
// one Keccak rate block and offers it to the permutation core.
//
// Handshake: blkvld/blkrdy are strict valid/ready. blkvld rises when a block
// is complete (or closed early by flush), holds blkdat/blkwords stable and
// never drops until a cycle with blkvld && blkrdy, after which the block
// register clears and word fetching restarts in the very next cycle.
module fifo_blk_drain
    import keccak_fifo_pkg::*;
(
    input  logic                rdclk,
    input  logic                rdrst,
    input  logic                fifordy,
    output logic                fifoget,
    input  logic                fifovld,
    input  logic [DW-1:0]       fifodout,
    input  logic                flush,
    output logic                blkvld,
    input  logic                blkrdy,
    output logic [NWORD*DW-1:0] blkdat,
    output logic [CW-1:0]       blkwords,
    output logic                protoerr,
    output state_t              dbg_state
);

    state_t        state_q, state_d;
    logic [CW-1:0] fill_q, fill_d;
    blk_t          blk_q, blk_d;
    logic          hold;
    logic          word_acc;
    logic          close;
    logic          outs_zero;

    assign hold = (state_q == HOLD);

    fifo_get_ctrl u_get_ctrl (
        .clk_i       (rdclk),
        .rst_i       (rdrst),
        .hold_i      (hold),
        .fill_i      (fill_q),
        .fifordy_i   (fifordy),
        .fifovld_i   (fifovld),
        .flush_i     (flush),
        .fifoget_o   (fifoget),
        .word_acc_o  (word_acc),
        .close_o     (close),
        .outs_zero_o (outs_zero),
        .protoerr_o  (protoerr)
    );

    // FILL/HOLD FSM: store returned words, close the block, hand it over.
    always_comb begin
        state_d = state_q;
        fill_d  = fill_q;
        blk_d   = blk_q;
        if (state_q == FILL) begin
            if (word_acc) begin
                for (int i = 0; i < NWORD; i++) begin
                    if (fill_q == CW'(i)) begin
                        blk_d[i*DW +: DW] = fifodout;
                    end
                end
                fill_d = fill_q + CW'(1);
            end
            // Full block wins over a same-cycle flush; an early close only
            // happens with at least one word and nothing left in flight.
            if (outs_zero && ((fill_d == CW'(NWORD)) || (close && (fill_d != '0)))) begin
                state_d = HOLD;
            end
        end else begin
            if (blkrdy) begin
                state_d = FILL;
                fill_d  = '0;
                blk_d   = '0;
            end
        end
    end

    // State, fill count and block register.
    always_ff @(posedge rdclk) begin
        if (rdrst) begin
            state_q <= FILL;
            fill_q  <= '0;
            blk_q   <= '0;
        end else begin
            state_q <= state_d;
            fill_q  <= fill_d;
            blk_q   <= blk_d;
        end
    end

    assign blkvld    = hold;
    assign blkwords  = hold ? fill_q : '0;
    assign blkdat    = blk_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_fifo_blk_drain.sv
// Directed bench for fifo_blk_drain with a small FIFO read-side model whose
// read latency can be changed between scenarios.
module tb_fifo_blk_drain;
    import keccak_fifo_pkg::*;

    // ---------------- clock / reset / DUT ----------------
    logic          rdclk;
    logic          rdrst;
    logic          fifordy;
    logic          fifoget;
    logic          fifovld;
    logic [DW-1:0] fifodout;
    logic          flush;
    logic          blkvld;
    logic          blkrdy;
    blk_t          blkdat;
    logic [CW-1:0] blkwords;
    logic          protoerr;
    state_t        dbg_state;

    initial begin
        rdclk = 1'b0;
        forever #5 rdclk = ~rdclk;
    end

    fifo_blk_drain dut (
        .rdclk     (rdclk),
        .rdrst     (rdrst),
        .fifordy   (fifordy),
        .fifoget   (fifoget),
        .fifovld   (fifovld),
        .fifodout  (fifodout),
        .flush     (flush),
        .blkvld    (blkvld),
        .blkrdy    (blkrdy),
        .blkdat    (blkdat),
        .blkwords  (blkwords),
        .protoerr  (protoerr),
        .dbg_state (dbg_state)
    );

    // ---------------- bench state ----------------
    int            n_chk;
    int            n_fail;
    int            lat;
    logic [DW-1:0] next_val;
    logic          pv [0:3];
    logic [DW-1:0] pd [0:3];
    logic [DW-1:0] exp_q [$];
    int            get_cnt;
    int            hold_gets;
    int            outs_m;
    int            max_outs;

    logic          s_get;
    logic          s_blkvld;
    logic [CW-1:0] s_words;
    blk_t          s_dat;
    logic          s_perr;
    state_t        s_state;

    // ---------------- scoreboard check ----------------
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] word_at(input blk_t d, input int i);
        return d[i*DW +: DW];
    endfunction

    // ---------------- driver tasks ----------------
    // One clock cycle: sample outputs mid-cycle, then advance the FIFO model
    // and drive this cycle's read data just after the edge.
    task automatic cycle();
        @(negedge rdclk);
        s_get    = fifoget;
        s_blkvld = blkvld;
        s_words  = blkwords;
        s_dat    = blkdat;
        s_perr   = protoerr;
        s_state  = dbg_state;
        if (s_get) get_cnt++;
        if (s_get && s_blkvld) hold_gets++;
        if (s_get && !fifovld) outs_m++;
        else if (!s_get && fifovld && outs_m > 0) outs_m--;
        if (outs_m > max_outs) max_outs = outs_m;
        @(posedge rdclk);
        #1;
        for (int k = 0; k < 3; k++) begin
            pv[k] = pv[k+1];
            pd[k] = pd[k+1];
        end
        pv[3] = 1'b0;
        pd[3] = '0;
        if (s_get) begin
            pv[lat-1] = 1'b1;
            pd[lat-1] = next_val;
            exp_q.push_back(next_val);
            next_val = next_val + 32'd10;
        end
        fifovld  = pv[0];
        fifodout = pd[0];
    endtask

    task automatic do_reset();
        rdrst    = 1'b1;
        fifordy  = 1'b0;
        flush    = 1'b0;
        blkrdy   = 1'b0;
        fifovld  = 1'b0;
        fifodout = '0;
        for (int k = 0; k < 4; k++) begin
            pv[k] = 1'b0;
            pd[k] = '0;
        end
        cycle();
        cycle();
        rdrst     = 1'b0;
        exp_q.delete();
        next_val  = '0;
        get_cnt   = 0;
        hold_gets = 0;
        outs_m    = 0;
        max_outs  = 0;
    endtask

    // Run until blkvld is sampled high; n = cycles consumed.
    task automatic wait_blk(input string tag, input int limit, output int n);
        n = 0;
        s_blkvld = 1'b0;
        while (!s_blkvld && n < limit) begin
            cycle();
            n++;
        end
        if (!s_blkvld) check({tag, "_timeout"}, s_blkvld, 1);
    endtask

    // ---------------- scenarios ----------------
    initial begin
        int   n;
        int   drops;
        int   changes;
        int   errs;
        int   seen;
        blk_t dat0;
        logic [DW-1:0] e;

        n_chk  = 0;
        n_fail = 0;
        lat    = 1;

        // Reset state
        do_reset();
        check("rst_fifoget", s_get, 0);
        check("rst_blkvld", s_blkvld, 0);
        check("rst_blkwords", s_words, 0);
        check("rst_blkdat_zero", (s_dat == '0), 1);
        check("rst_protoerr", s_perr, 0);
        check("rst_state", s_state, FILL);

        // Full block, 0,10,...,330, core always ready
        fifordy = 1'b1;
        blkrdy  = 1'b1;
        wait_blk("full", 200, n);
        check("full_blkvld_cycle", n - 1, 35);
        check("full_gets", get_cnt, 34);
        check("full_blkwords", s_words, 34);
        check("full_word0", word_at(s_dat, 0), 0);
        check("full_word17", word_at(s_dat, 17), 170);
        check("full_word33", word_at(s_dat, 33), 330);
        check("full_protoerr", s_perr, 0);
        cycle();
        check("full_blkvld_drop", s_blkvld, 0);
        check("full_get_resume", s_get, 1);
        check("full_blkdat_cleared", (s_dat == '0), 1);

        // Backpressure: core stalls 20 cycles on the second block
        blkrdy = 1'b0;
        wait_blk("bp", 200, n);
        check("bp_blkwords", s_words, 34);
        check("bp_word0", word_at(s_dat, 0), 340);
        check("bp_word33", word_at(s_dat, 33), 670);
        dat0      = s_dat;
        drops     = 0;
        changes   = 0;
        hold_gets = 0;
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (!s_blkvld) drops++;
            if (s_dat !== dat0) changes++;
        end
        check("bp_blkvld_drops", drops, 0);
        check("bp_blkdat_changes", changes, 0);
        check("bp_gets_in_hold", hold_gets, 0);
        blkrdy = 1'b1;
        cycle();
        blkrdy = 1'b0;
        cycle();
        check("bp_after_accept_blkvld", s_blkvld, 0);
        check("bp_after_accept_get", s_get, 1);

        // Partial flush after 10 words
        do_reset();
        fifordy = 1'b1;
        repeat (9) cycle();
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        wait_blk("pflush", 50, n);
        check("pflush_close_lat", n, 2);
        check("pflush_gets", get_cnt, 10);
        check("pflush_blkwords", s_words, 10);
        check("pflush_word0", word_at(s_dat, 0), 0);
        check("pflush_word9", word_at(s_dat, 9), 90);
        errs = 0;
        for (int i = 10; i < NWORD; i++) begin
            if (word_at(s_dat, i) != '0) errs++;
        end
        check("pflush_zero_pad", errs, 0);
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        cycle();
        check("pflush_hold_flush_blkvld", s_blkvld, 1);
        check("pflush_hold_flush_words", s_words, 10);
        blkrdy = 1'b1;
        cycle();
        blkrdy = 1'b0;
        cycle();
        check("pflush_accept_blkvld", s_blkvld, 0);
        check("pflush_accept_get", s_get, 1);

        // Flush with nothing stored or in flight is dropped
        do_reset();
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            cycle();
            if (s_blkvld) seen++;
        end
        check("eflush_no_blkvld", seen, 0);
        fifordy = 1'b1;
        blkrdy  = 1'b1;
        cycle();
        check("eflush_get_resume", s_get, 1);
        wait_blk("eflush", 200, n);
        check("eflush_blkwords", s_words, 34);
        check("eflush_word33", word_at(s_dat, 33), 330);

        // Read latency 2 with fifordy toggling every cycle
        do_reset();
        lat    = 2;
        blkrdy = 1'b1;
        n      = 0;
        s_blkvld = 1'b0;
        while (!s_blkvld && n < 400) begin
            fifordy = n[0];
            cycle();
            n++;
        end
        if (!s_blkvld) check("gap_timeout", s_blkvld, 1);
        check("gap_outs_max_le2", (max_outs <= 2), 1);
        check("gap_gets", get_cnt, 34);
        check("gap_blkwords", s_words, 34);
        check("gap_word33", word_at(s_dat, 33), 330);
        errs = 0;
        for (int i = 0; i < NWORD; i++) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hFFFF_FFFF;
            if (word_at(s_dat, i) !== e) errs++;
        end
        check("gap_in_order", errs, 0);
        fifordy = 1'b0;
        lat     = 1;

        // Stray fifovld sets sticky protoerr; reset mid-block clears all
        do_reset();
        fifovld  = 1'b1;
        fifodout = 32'hDEAD_BEEF;
        cycle();
        cycle();
        check("err_protoerr_set", s_perr, 1);
        next_val = 32'd5;
        fifordy  = 1'b1;
        repeat (7) cycle();
        fifordy = 1'b0;
        cycle();
        cycle();
        check("err_protoerr_sticky", s_perr, 1);
        check("err_stray_dropped_word0", word_at(s_dat, 0), 5);
        check("err_word6", word_at(s_dat, 6), 65);
        check("err_no_blkvld", s_blkvld, 0);
        rdrst = 1'b1;
        cycle();
        rdrst = 1'b0;
        cycle();
        check("mrst_protoerr", s_perr, 0);
        check("mrst_blkvld", s_blkvld, 0);
        check("mrst_fifoget", s_get, 0);
        check("mrst_blkwords", s_words, 0);
        check("mrst_blkdat_zero", (s_dat == '0), 1);
        fifordy = 1'b1;
        blkrdy  = 1'b1;
        wait_blk("mrst", 200, n);
        check("mrst_refill_words", s_words, 34);
        check("mrst_refill_word0", word_at(s_dat, 0), 75);
        check("mrst_refill_protoerr", s_perr, 0);

        // ---------------- final report ----------------
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
